// File: rtl/board_io_ctrl_pkg.sv
// Shared definitions for the board I/O controller: register map and 7-segment decode.
package board_io_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] OFS_LED  = 5'h00;
  localparam logic [ADDR_W-1:0] OFS_DISP = 5'h04;
  localparam logic [ADDR_W-1:0] OFS_CTRL = 5'h08;
  localparam logic [ADDR_W-1:0] OFS_SW   = 5'h0C;
  localparam logic [ADDR_W-1:0] OFS_BTN  = 5'h10;
  localparam logic [ADDR_W-1:0] OFS_EDGE = 5'h14;

  // Word selects as seen on addr_i[4:2]
  localparam logic [2:0] SEL_LED  = OFS_LED[4:2];
  localparam logic [2:0] SEL_DISP = OFS_DISP[4:2];
  localparam logic [2:0] SEL_CTRL = OFS_CTRL[4:2];
  localparam logic [2:0] SEL_SW   = OFS_SW[4:2];
  localparam logic [2:0] SEL_BTN  = OFS_BTN[4:2];
  localparam logic [2:0] SEL_EDGE = OFS_EDGE[4:2];

  // Active-low segment pattern, bit order g..a
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and rise pulse.
module io_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive mismatching cycles; any match restarts the count
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = s2_q;
        rise_d  = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Memory-mapped board I/O: LEDs, multiplexed 7-segment display, switches and debounced buttons.
module board_io_ctrl
  import board_io_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned NUM_BTN    = 5,
  parameter int unsigned NUM_SW     = 8,
  parameter int unsigned NUM_LED    = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DB_CYCLES  = 1000000
) (
  input  logic                  clk_100mhz,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     data_o,
  input  logic [NUM_BTN-1:0]    btn_i,
  input  logic [NUM_SW-1:0]     sw_i,
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [NUM_LED-1:0]    led_o,
  output logic                  int_o
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = 4 * NUM_DIGITS;

  logic [NUM_LED-1:0]    led_q, led_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic                  en_q, en_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_BTN-1:0]    edge_q, edge_d;
  logic                  int_q;
  logic [NUM_SW-1:0]     sw_s1_q, sw_s2_q;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [NUM_BTN-1:0]    btn_lvl, btn_rise;
  logic [DATA_W-1:0]     rdata_c;
  logic [3:0]            nib_c;
  logic                  dp_c;
  logic                  wr_c;
  logic [2:0]            sel_c;
  logic                  wrap_c;
  logic                  unused_c;

  assign wr_c     = ce_i & we_i;
  assign sel_c    = addr_i[4:2];
  assign unused_c = ^{addr_i[1:0], data_i};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i   (clk_100mhz),
      .rst_i   (rst),
      .btn_i   (btn_i[b]),
      .level_o (btn_lvl[b]),
      .rise_o  (btn_rise[b])
    );
  end

  // Register writes; a press in the same cycle as its W1C wins
  always_comb begin
    led_d  = led_q;
    disp_d = disp_q;
    en_d   = en_q;
    dp_d   = dp_q;
    edge_d = edge_q;
    if (wr_c) begin
      case (sel_c)
        SEL_LED:  led_d  = data_i[NUM_LED-1:0];
        SEL_DISP: disp_d = data_i[DW-1:0];
        SEL_CTRL: begin
          en_d = data_i[0];
          dp_d = data_i[8 +: NUM_DIGITS];
        end
        SEL_EDGE: edge_d = edge_q & ~data_i[NUM_BTN-1:0];
        default: ;
      endcase
    end
    edge_d = edge_d | btn_rise;
  end

  // Scan prescaler and digit index
  always_comb begin
    wrap_c  = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = wrap_c ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (wrap_c) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Digit drive for the current index
  always_comb begin
    nib_c = '0;
    dp_c  = 1'b0;
    an_d  = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        nib_c = disp_q[4*d +: 4];
        dp_c  = dp_q[d];
        an_d[d] = ~en_q;
      end
    end
    seg_d = en_q ? {~dp_c, hex_to_seg(nib_c)} : 8'hFF;
  end

  always_comb begin
    rdata_c = '0;
    if (ce_i && !we_i) begin
      case (sel_c)
        SEL_LED:  rdata_c[NUM_LED-1:0] = led_q;
        SEL_DISP: rdata_c[DW-1:0]      = disp_q;
        SEL_CTRL: begin
          rdata_c[0]              = en_q;
          rdata_c[8 +: NUM_DIGITS] = dp_q;
        end
        SEL_SW:   rdata_c[NUM_SW-1:0]  = sw_s2_q;
        SEL_BTN:  rdata_c[NUM_BTN-1:0] = btn_lvl;
        SEL_EDGE: rdata_c[NUM_BTN-1:0] = edge_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      led_q   <= '0;
      disp_q  <= '0;
      en_q    <= 1'b0;
      dp_q    <= '0;
      edge_q  <= '0;
      int_q   <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
    end else begin
      led_q   <= led_d;
      disp_q  <= disp_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      edge_q  <= edge_d;
      int_q   <= |edge_q;
      sw_s1_q <= sw_i;
      sw_s2_q <= sw_s1_q;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign data_o = rdata_c;
  assign led_o  = led_q;
  assign seg_o  = seg_q;
  assign an_o   = an_q;
  assign int_o  = int_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: expectations queued by cycle, checked by a negedge monitor.
module tb_board_io_ctrl;

  localparam int SEL_DATA = 0;
  localparam int SEL_LEDO = 1;
  localparam int SEL_AN   = 2;
  localparam int SEL_SEG  = 3;
  localparam int SEL_INT  = 4;

  typedef struct {
    int unsigned due;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [4:0]  btn_i = '0;
  logic [7:0]  sw_i = '0;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic [7:0]  led_o;
  logic        int_o;

  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  exp_t        sb[$];
  exp_t        keep[$];
  logic [31:0] act;

  logic [3:0] an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] seg_tbl[4] = '{8'hC0, 8'h08, 8'hF9, 8'h80};

  board_io_ctrl #(
    .NUM_DIGITS(4), .NUM_BTN(5), .NUM_SW(8), .NUM_LED(8),
    .SCAN_DIV(4), .DB_CYCLES(8)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .ce_i       (ce_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .btn_i      (btn_i),
    .sw_i       (sw_i),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .led_o      (led_o),
    .int_o      (int_o)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SEL_DATA: return data_o;
      SEL_LEDO: return 32'(led_o);
      SEL_AN:   return 32'(an_o);
      SEL_SEG:  return 32'(seg_o);
      default:  return 32'(int_o);
    endcase
  endfunction

  // Monitor: compare every expectation whose cycle has come
  always @(negedge clk_100mhz) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        act = sample(sb[i].sel);
        n_total++;
        if (act === sb[i].val) n_pass++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", sb[i].name, cyc, act, sb[i].val);
      end else if (sb[i].due < cyc) begin
        n_total++;
        $display("FAIL %s: expectation for cyc %0d expired", sb[i].name, sb[i].due);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic expect_at(input int unsigned due, input int sel, input logic [31:0] val,
                           input string name);
    exp_t e;
    e.due = due; e.sel = sel; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_digit(input int unsigned due, input int d, input string name);
    expect_at(due, SEL_AN, 32'(an_tbl[d]), {name, "_an"});
    expect_at(due, SEL_SEG, 32'(seg_tbl[d]), {name, "_seg"});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick(1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    tick(1);
    ce_i = 1'b0; we_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a;
    expect_at(cyc, SEL_DATA, exp, name);
    tick(1);
    ce_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    int unsigned p;
    tick(2);
    r = cyc;
    // Reset values, then start the display from a known scan phase
    expect_at(r, SEL_LEDO, 32'h0, "rst_led");
    expect_at(r, SEL_AN, 32'hF, "rst_an");
    expect_at(r, SEL_SEG, 32'hFF, "rst_seg");
    expect_at(r, SEL_INT, 32'h0, "rst_int");
    expect_at(r, SEL_DATA, 32'h0, "rst_data");
    rst = 1'b0;
    wr(5'h04, 32'h81A0);
    wr(5'h08, 32'h201);
    expect_at(r + 2, SEL_SEG, 32'hFF, "pre_en_seg");
    expect_at(r + 2, SEL_AN, 32'hF, "pre_en_an");
    expect_digit(r + 3, 0, "scan_d0a");
    expect_digit(r + 4, 0, "scan_d0b");
    expect_digit(r + 5, 1, "scan_d1");
    expect_digit(r + 9, 2, "scan_d2");
    expect_digit(r + 13, 3, "scan_d3");
    expect_digit(r + 17, 0, "scan_wrap");
    wait_until(r + 17);
    wr(5'h08, 32'h200);
    expect_at(r + 19, SEL_SEG, 32'hFF, "dis_seg");
    expect_at(r + 19, SEL_AN, 32'hF, "dis_an");
    expect_at(r + 20, SEL_SEG, 32'hFF, "dis_seg2");
    wait_until(r + 20);
    wr(5'h08, 32'h201);
    expect_digit(r + 22, 1, "reen_d1");
    expect_digit(r + 25, 2, "reen_d2");
    wait_until(r + 26);
    rd(5'h04, 32'h81A0, "rd_disp");
    rd(5'h08, 32'h201, "rd_ctrl");
    rd(5'h18, 32'h0, "rd_unmapped");
    addr_i = 5'h04;
    expect_at(cyc, SEL_DATA, 32'h0, "rd_no_ce");
    tick(1);

    // LED write/read and ignored writes
    expect_at(cyc, SEL_LEDO, 32'h0, "led_before");
    wr(5'h00, 32'h5A);
    expect_at(cyc, SEL_LEDO, 32'h5A, "led_after");
    rd(5'h00, 32'h5A, "rd_led");
    wr(5'h1C, 32'hFFFF_FFFF);
    wr(5'h0C, 32'hFFFF_FFFF);
    rd(5'h00, 32'h5A, "led_kept");
    rd(5'h08, 32'h201, "ctrl_kept");

    // Switch synchroniser latency
    sw_i = 8'hC3;
    tick(1);
    rd(5'h0C, 32'h0, "sw_1cyc");
    rd(5'h0C, 32'hC3, "sw_2cyc");

    // Short glitch on btn[2] is rejected
    p = cyc;
    btn_i = 5'b00100;
    wait_until(p + 5);
    btn_i = 5'b00000;
    wait_until(p + 10);
    rd(5'h10, 32'h0, "glitch_btn");
    wait_until(p + 12);
    expect_at(cyc, SEL_INT, 32'h0, "glitch_int");
    rd(5'h14, 32'h0, "glitch_edge");

    // Held btn[2] is accepted after 8 stable cycles
    wait_until(p + 14);
    p = cyc;
    btn_i = 5'b00100;
    expect_at(p + 11, SEL_INT, 32'h0, "press_int_early");
    expect_at(p + 12, SEL_INT, 32'h1, "press_int");
    wait_until(p + 9);
    rd(5'h10, 32'h0, "press_btn_early");
    rd(5'h10, 32'h4, "press_btn");
    rd(5'h14, 32'h4, "press_edge");
    wait_until(p + 12);
    btn_i = 5'b00000;
    wait_until(p + 23);
    rd(5'h10, 32'h0, "release_btn");
    rd(5'h14, 32'h4, "edge_sticky");

    // W1C of bit 2 coincident with a new btn[0] edge
    p = cyc;
    btn_i = 5'b00001;
    expect_at(p + 11, SEL_INT, 32'h1, "w1c_int_a");
    expect_at(p + 12, SEL_INT, 32'h1, "w1c_int_b");
    wait_until(p + 10);
    wr(5'h14, 32'h4);
    rd(5'h14, 32'h1, "w1c_edge");
    btn_i = 5'b00000;
    wait_until(p + 24);

    // Reset mid-debounce discards the partial count
    p = cyc;
    btn_i = 5'b00010;
    expect_at(p + 5, SEL_LEDO, 32'h5A, "prerst_led");
    expect_at(p + 5, SEL_INT, 32'h1, "prerst_int");
    wait_until(p + 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_at(cyc, SEL_LEDO, 32'h0, "mrst_led");
    expect_at(cyc, SEL_AN, 32'hF, "mrst_an");
    expect_at(cyc, SEL_SEG, 32'hFF, "mrst_seg");
    expect_at(cyc, SEL_INT, 32'h0, "mrst_int");
    wait_until(p + 15);
    rd(5'h10, 32'h0, "mrst_btn_early");
    rd(5'h10, 32'h2, "mrst_btn");
    tick(3);

    foreach (sb[i]) begin
      n_total++;
      $display("FAIL %s: expectation for cyc %0d never sampled", sb[i].name, sb[i].due);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
